alarm_input_pio: RTL and testbench

ALARM_INPUT_PIO -- requirements
Module: alarm_input_pio

---
 rtl/alarm_pio_pkg.sv | 30 +++
 rtl/alarm_input_debounce.sv | 50 +++++
 rtl/alarm_input_pio.sv | 101 ++++++++++
 tb/tb_alarm_input_pio.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pio_pkg.sv
// alarm_pio_pkg: shared definitions for the alarm input PIO.
// Holds the Avalon-MM register addresses, the EDGE_MODE encodings and
// the per-bit edge qualification helper used by the top level.
package alarm_pio_pkg;

  // Register map (word addresses on the 2-bit Avalon-MM address bus)
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // EDGE_MODE encodings
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned BUS_W = 32;

  // True when the transition prev -> cur is one the selected mode captures.
  function automatic logic edge_match(input int unsigned mode, input logic prev, input logic cur);
    logic hit;
    case (mode)
      EDGE_RISING:  hit = ~prev & cur;
      EDGE_FALLING: hit = prev & ~cur;
      default:      hit = prev ^ cur;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/alarm_input_debounce.sv
// alarm_input_debounce: 2-flop synchronizer plus debounce for one input bit.
// Ports:
//   clk, reset   - sole clock, synchronous active-high reset
//   in_bit       - asynchronous external input
//   stable       - debounced level; toggles only after DEBOUNCE_CYCLES
//                  consecutive synchronized samples disagree with it
module alarm_input_debounce
  import alarm_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // cnt never exceeds CNT_MAX-1 in the register, so the increment cannot wrap
  assign cnt_inc = cnt + CNT_W'(1);

  // Synchronizer, disagreement counter and stable level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
    end else begin
      sync_q1 <= in_bit;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt_inc == CNT_MAX) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/alarm_input_pio.sv
// alarm_input_pio: debounced parallel input port with edge capture and a
// maskable level interrupt, exposed as a 4-word Avalon-MM slave.
// Ports:
//   clk, reset            - sole clock, synchronous active-high reset
//   address               - register select (data/rsvd/irqmask/edgecap)
//   chipselect, write_n   - write qualifier and active-low write strobe
//   writedata             - write data; bits above WIDTH are ignored
//   in_port               - asynchronous external inputs
//   readdata              - addressed register, 1-cycle latency, zero-extended
//   irq                   - OR of (edgecapture & interruptmask)
module alarm_input_pio
  import alarm_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_MODE       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [BUS_W-1:0]  writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [BUS_W-1:0]  readdata,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_edgecap;
  logic             unused_wdata;

  // Per-bit synchronizer and debounce
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    alarm_input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .in_bit (in_port[i]),
      .stable (stable[i])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign wr_mask      = wr_en && (address == ADDR_IRQMASK);
  assign wr_edgecap   = wr_en && (address == ADDR_EDGECAP);
  assign wdata_w      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Qualify each stable-bit transition against the configured edge mode
  always_comb begin
    edge_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_set[i] = edge_match(EDGE_MODE, stable_d[i], stable[i]);
    end
  end

  // Read mux; reserved and out-of-map reads return zero
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = stable;
      ADDR_IRQMASK: rd_mux = irqmask;
      ADDR_EDGECAP: rd_mux = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  // Register file; a capture in the same cycle as a W1C keeps the bit set
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      stable_d <= stable;
      if (wr_mask) begin
        irqmask <= wdata_w;
      end
      if (wr_edgecap) begin
        edgecap <= (edgecap & ~wdata_w) | edge_set;
      end else begin
        edgecap <= edgecap | edge_set;
      end
      readdata <= BUS_W'(rd_mux);
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_alarm_input_pio.sv
// tb_alarm_input_pio: self-checking bench for alarm_input_pio.
// dut uses EDGE_MODE=any, dut2 uses EDGE_MODE=rising; both share the bus.
module tb_alarm_input_pio;
  import alarm_pio_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [W-1:0]  in_port2;
  logic [31:0]   readdata;
  logic [31:0]   readdata2;
  logic          irq;
  logic          irq2;

  always #5 clk = ~clk;

  alarm_input_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_ANY)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  alarm_input_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_RISING)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_idle;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    bus_idle();
  endtask

  // Reference model for dut: an input level is accepted once the last D
  // synchronized samples (in_port seen two edges late) all disagree with it.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_stable, m_stable_d, m_edgecap, m_mask;
  logic [31:0]  m_rd;

  always @(posedge clk) begin
    logic [W-1:0] nx_stable;
    logic [W-1:0] clr;
    logic [31:0]  nx_rd;
    bit           all_diff;
    if (reset) begin
      m_stable = '0; m_stable_d = '0; m_edgecap = '0; m_mask = '0; m_rd = '0;
      m_hist.delete();
      for (int j = 0; j <= D; j++) m_hist.push_back('0);
    end else begin
      nx_stable = m_stable;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (m_hist[j][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) nx_stable[b] = ~m_stable[b];
      end
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      case (address)
        2'd0:    nx_rd = 32'(m_stable);
        2'd2:    nx_rd = 32'(m_mask);
        2'd3:    nx_rd = 32'(m_edgecap);
        default: nx_rd = '0;
      endcase
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_edgecap  = (m_edgecap & ~clr) | (m_stable ^ m_stable_d);
      m_stable_d = m_stable;
      m_stable   = nx_stable;
      m_rd       = nx_rd;
      m_hist.push_back(in_port);
      void'(m_hist.pop_front());
    end
  end

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // One bus cycle per entry; exp is readdata after that edge (pre-write contents)
    tbl[0]  = '{2'd2, 1'b1, 32'h0000000F, 32'h1};
    tbl[1]  = '{2'd2, 1'b0, 32'h0,        32'hF};
    tbl[2]  = '{2'd2, 1'b1, 32'hFFFFFFF2, 32'hF};
    tbl[3]  = '{2'd2, 1'b0, 32'h0,        32'h2};
    tbl[4]  = '{2'd1, 1'b1, 32'hFFFFFFFF, 32'h0};
    tbl[5]  = '{2'd1, 1'b0, 32'h0,        32'h0};
    tbl[6]  = '{2'd0, 1'b1, 32'h0000000E, 32'h1};
    tbl[7]  = '{2'd0, 1'b0, 32'h0,        32'h1};
    tbl[8]  = '{2'd3, 1'b1, 32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{2'd3, 1'b0, 32'h0,        32'h0};
    tbl[10] = '{2'd2, 1'b1, 32'h0,        32'h2};
    tbl[11] = '{2'd2, 1'b0, 32'h0,        32'h0};

    reset = 1'b1; address = 2'd0; in_port = '0; in_port2 = '1;
    bus_idle();
    ticks(3);
    reset = 1'b0;
    tick();
    check("reset_rd", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_rd2", readdata2, 32'h0);
    check("reset_irq2", {31'b0, irq2}, 32'h0);

    // dut2 input held high through reset: stable 2+D edges after release
    ticks(5);
    check("held_rd2_edge6", readdata2, 32'h0);
    tick();
    check("held_rd2_edge7", readdata2, 32'hF);
    address = 2'd3;
    tick();
    check("held_edgecap2", readdata2, 32'hF);

    // Short glitch on bit0 is rejected
    address = 2'd0;
    in_port = 4'h1;
    ticks(3);
    in_port = 4'h0;
    ticks(10);
    check("glitch_data", readdata, 32'h0);
    address = 2'd3;
    tick();
    check("glitch_edgecap", readdata, 32'h0);

    // 0x0 -> 0x5 accepted after 2+D edges, visible on readdata one edge later
    address = 2'd0;
    in_port = 4'h5;
    ticks(6);
    check("data_edge6", readdata, 32'h0);
    tick();
    check("data_edge7", readdata, 32'h5);
    address = 2'd3;
    tick();
    check("edgecap_5", readdata, 32'h5);
    check("irq_nomask", {31'b0, irq}, 32'h0);

    // Masked interrupt and W1C
    bus_write(2'd2, 32'h1);
    check("irq_masked", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    tick();
    check("edgecap_after_w1c", readdata, 32'h4);
    address = 2'd2;
    tick();
    check("mask_readback", readdata, 32'h1);

    // W1C of bit2 in the very cycle a new bit2 (falling) edge is captured
    in_port = 4'h1;
    ticks(6);
    address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h4;
    tick();
    bus_idle();
    tick();
    check("set_beats_clear", readdata, 32'h4);
    bus_write(2'd3, 32'h4);
    tick();
    check("w1c_bit2", readdata, 32'h0);

    // Register access table
    foreach (tbl[i]) begin
      address = tbl[i].addr;
      chipselect = tbl[i].wr;
      write_n = ~tbl[i].wr;
      writedata = tbl[i].wd;
      tick();
      bus_idle();
      check($sformatf("tbl%0d", i), readdata, tbl[i].exp);
    end

    // Randomized traffic against the reference model
    for (int it = 0; it < 50; it++) begin
      int hold;
      in_port = W'($urandom);
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        address = 2'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
        end else begin
          bus_idle();
        end
        tick();
        check("rand_rd", readdata, m_rd);
        check("rand_irq", {31'b0, irq}, {31'b0, |(m_edgecap & m_mask)});
      end
    end
    bus_idle();

    // Reset mid-debounce discards the partial count
    in_port = '0; in_port2 = '1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(10);
    bus_write(2'd3, 32'hFFFFFFFF);
    address = 2'd0;
    in_port = 4'h3;
    ticks(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(6);
    check("rst_mid_edge6", readdata, 32'h0);
    check("rst_mid_edge6_2", readdata2, 32'h0);
    tick();
    check("rst_mid_edge7", readdata, 32'h3);
    check("rst_mid_edge7_2", readdata2, 32'hF);
    address = 2'd3;
    tick();
    check("rst_mid_edgecap", readdata, 32'h3);
    check("rst_mid_edgecap2", readdata2, 32'hF);

    // Rising-only mode ignores a falling transition
    bus_write(2'd3, 32'hFFFFFFFF);
    in_port2 = 4'h0;
    address = 2'd0;
    ticks(10);
    check("fall_data2", readdata2, 32'h0);
    address = 2'd3;
    tick();
    check("fall_edgecap2", readdata2, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
